// File: rtl/ripple_count_monitor_pkg.sv
// Shared definitions for the ripple counter monitor: FSM state codes and the
// modular decrement helper used to recognise a single down-step.
package ripple_count_monitor_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT  = 1'b0;
    localparam state_t ST_TRACK = 1'b1;

    // (v - 1) mod 2^w, for any w up to 32 bits
    function automatic logic [31:0] dec_mod(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v - 32'd1) & mask;
    endfunction

endpackage

// File: rtl/ripple_count_monitor_sync2.sv
// Two-flop synchronizer, one independent chain per bit; bits are not coherent
// with each other, the downstream stability filter takes care of that.
module ripple_count_monitor_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic s1_q, s1_d;
            logic s2_q, s2_d;

            always_comb begin
                s1_d = d[gi];
                s2_d = s1_q;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                end else begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                end
            end

            assign q[gi] = s2_q;
        end
    endgenerate

endmodule

// File: rtl/ripple_count_monitor.sv
// Observes an asynchronous ripple down-counter, accepts only values that stay
// stable for STABLE cycles, and reports down-steps, wraps and skipped steps.
module ripple_count_monitor
    import ripple_count_monitor_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STABLE = 2,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr,
    output logic [WIDTH-1:0]  count_out,
    output logic              valid,
    output logic              dec_pulse,
    output logic              wrap_pulse,
    output logic              skip_err,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [2:0] RUN_MAX = 3'(STABLE);

    logic [WIDTH-1:0]  s2;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [2:0]        run_q, run_d;
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              dec_q, dec_d;
    logic              wrap_q, wrap_d;
    logic              skip_q, skip_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              accept;
    logic [WIDTH-1:0]  count_dec;

    ripple_count_monitor_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_in),
        .q     (s2)
    );

    assign accept    = (run_q == RUN_MAX);
    assign count_dec = WIDTH'(dec_mod(32'(count_q), WIDTH));

    always_comb begin
        cand_d = s2;
        if (s2 == cand_q) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 3'd1;
        end else begin
            run_d = 3'd1;
        end

        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        dec_d   = 1'b0;
        wrap_d  = 1'b0;
        skip_d  = skip_q;
        wraps_d = wraps_q;

        // clr wins over a simultaneous accept; the filter keeps running
        if (clr) begin
            state_d = ST_INIT;
            valid_d = 1'b0;
            wraps_d = '0;
            skip_d  = 1'b0;
        end else if (accept) begin
            if (state_q == ST_INIT) begin
                count_d = cand_q;
                valid_d = 1'b1;
                state_d = ST_TRACK;
            end else if (cand_q != count_q) begin
                count_d = cand_q;
                if (cand_q == count_dec) begin
                    dec_d = 1'b1;
                    if (count_q == '0) begin
                        wrap_d = 1'b1;
                        if (wraps_q != '1) begin
                            wraps_d = wraps_q + WRAP_W'(1);
                        end
                    end
                end else begin
                    skip_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q  <= '0;
            run_q   <= '0;
            state_q <= ST_INIT;
            count_q <= '0;
            valid_q <= 1'b0;
            dec_q   <= 1'b0;
            wrap_q  <= 1'b0;
            skip_q  <= 1'b0;
            wraps_q <= '0;
        end else begin
            cand_q  <= cand_d;
            run_q   <= run_d;
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            dec_q   <= dec_d;
            wrap_q  <= wrap_d;
            skip_q  <= skip_d;
            wraps_q <= wraps_d;
        end
    end

    assign count_out  = count_q;
    assign valid      = valid_q;
    assign dec_pulse  = dec_q;
    assign wrap_pulse = wrap_q;
    assign skip_err   = skip_q;
    assign wraps      = wraps_q;

endmodule
